// File: rtl/execute_result_buffer_if.sv
// rtl/execute_result_buffer_if.sv - upstream/downstream handshake bundle for execute_result_buffer
interface execute_result_buffer_if #(
    parameter int P_N = 32
);
    // Upstream (execute units -> buffer)
    logic           iPREV_VALID;
    logic           oPREV_BUSY;
    logic [P_N-1:0] iPREV_DATA;
    logic [4:0]     iPREV_DESTINATION;
    logic           iPREV_WRITEBACK;
    logic           iPREV_FLAGS_WRITEBACK;
    logic [4:0]     iPREV_FLAGS;

    // Downstream (buffer -> write-back stage)
    logic           oNEXT_VALID;
    logic           iNEXT_BUSY;
    logic [P_N-1:0] oNEXT_DATA;
    logic [4:0]     oNEXT_DESTINATION;
    logic           oNEXT_WRITEBACK;

    // Pipeline side: drives the upstream entry and the write-back stall
    modport master (
        output iPREV_VALID,
        input  oPREV_BUSY,
        output iPREV_DATA,
        output iPREV_DESTINATION,
        output iPREV_WRITEBACK,
        output iPREV_FLAGS_WRITEBACK,
        output iPREV_FLAGS,
        input  oNEXT_VALID,
        output iNEXT_BUSY,
        input  oNEXT_DATA,
        input  oNEXT_DESTINATION,
        input  oNEXT_WRITEBACK
    );

    // Buffer side
    modport slave (
        input  iPREV_VALID,
        output oPREV_BUSY,
        input  iPREV_DATA,
        input  iPREV_DESTINATION,
        input  iPREV_WRITEBACK,
        input  iPREV_FLAGS_WRITEBACK,
        input  iPREV_FLAGS,
        output oNEXT_VALID,
        input  iNEXT_BUSY,
        output oNEXT_DATA,
        output oNEXT_DESTINATION,
        output oNEXT_WRITEBACK
    );
endinterface

// File: rtl/execute_result_buffer.sv
// rtl/execute_result_buffer.sv - in-order result FIFO between execute and write-back, owns the flag register (optional forwarding: MIST1032SA_EXECUTE_RESULT_FORWARD_EN)
module execute_result_buffer #(
    parameter int P_N       = 32,
    parameter int P_DEPTH   = 2,
    parameter int P_DEPTH_N = 1
) (
    input  logic                   iCLOCK,
    input  logic                   iRESET_SYNC,
    input  logic                   iEVENT_FLUSH,
    execute_result_buffer_if.slave bus,
    output logic [4:0]             oFLAGS
`ifdef MIST1032SA_EXECUTE_RESULT_FORWARD_EN
    ,
    output logic                   oFWD_VALID,
    output logic [4:0]             oFWD_DESTINATION,
    output logic [P_N-1:0]         oFWD_DATA
`endif
);

    localparam logic [P_DEPTH_N:0] L_FULL = (P_DEPTH_N + 1)'(P_DEPTH);

    // Entry storage; contents are only meaningful between head and tail
    logic [P_N-1:0] data_q     [P_DEPTH];
    logic [4:0]     dest_q     [P_DEPTH];
    logic           wb_q       [P_DEPTH];
    logic           flags_wb_q [P_DEPTH];
    logic [4:0]     flags_q    [P_DEPTH];

    logic [P_DEPTH_N-1:0] head_q;
    logic [P_DEPTH_N-1:0] tail_q;
    logic [P_DEPTH_N:0]   count_q;
    logic [4:0]           arch_flags_q;

    logic next_valid;
    logic prev_busy;
    logic push;
    logic pop;

    // Status comes from the registered count only, so iNEXT_BUSY never reaches oPREV_BUSY
    assign next_valid = (count_q != '0);
    assign prev_busy  = (count_q == L_FULL);
    assign push       = bus.iPREV_VALID && !prev_busy;
    assign pop        = next_valid && !bus.iNEXT_BUSY;

    // Pointer and occupancy tracking; flush empties the buffer but keeps the pop's flag commit below
    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (iEVENT_FLUSH) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                tail_q <= tail_q + 1'b1;
            end
            if (pop) begin
                head_q <= head_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Capture the upstream entry at the tail; a push coinciding with flush is dropped
    always_ff @(posedge iCLOCK) begin
        if (push && !iEVENT_FLUSH && !iRESET_SYNC) begin
            data_q[tail_q]     <= bus.iPREV_DATA;
            dest_q[tail_q]     <= bus.iPREV_DESTINATION;
            wb_q[tail_q]       <= bus.iPREV_WRITEBACK;
            flags_wb_q[tail_q] <= bus.iPREV_FLAGS_WRITEBACK;
            flags_q[tail_q]    <= bus.iPREV_FLAGS;
        end
    end

    // Architectural flags change only when a flag-writing head entry is handed downstream
    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            arch_flags_q <= 5'h00;
        end else if (pop && flags_wb_q[head_q]) begin
            arch_flags_q <= flags_q[head_q];
        end
    end

    assign oFLAGS = arch_flags_q;

    // Head entry presentation, forced to zero while empty
    assign bus.oNEXT_VALID       = next_valid;
    assign bus.oPREV_BUSY        = prev_busy;
    assign bus.oNEXT_DATA        = next_valid ? data_q[head_q] : '0;
    assign bus.oNEXT_DESTINATION = next_valid ? dest_q[head_q] : 5'd0;
    assign bus.oNEXT_WRITEBACK   = next_valid ? wb_q[head_q]   : 1'b0;

`ifdef MIST1032SA_EXECUTE_RESULT_FORWARD_EN
    logic [P_DEPTH_N-1:0] fwd_idx;

    // Walk oldest to newest so the newest GPR-writing entry wins
    always_comb begin
        oFWD_VALID       = 1'b0;
        oFWD_DESTINATION = 5'd0;
        oFWD_DATA        = '0;
        fwd_idx          = '0;
        for (int i = 0; i < P_DEPTH; i++) begin
            fwd_idx = head_q + P_DEPTH_N'(i);
            if ((i < int'(count_q)) && wb_q[fwd_idx]) begin
                oFWD_VALID       = 1'b1;
                oFWD_DESTINATION = dest_q[fwd_idx];
                oFWD_DATA        = data_q[fwd_idx];
            end
        end
    end
`endif

endmodule

// File: tb/tb_execute_result_buffer.sv
// tb/tb_execute_result_buffer.sv - directed self-checking bench for execute_result_buffer
module tb_execute_result_buffer;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic [4:0] flags;
`ifdef MIST1032SA_EXECUTE_RESULT_FORWARD_EN
    logic        fwd_valid;
    logic [4:0]  fwd_dest;
    logic [31:0] fwd_data;
`endif

    int checks   = 0;
    int failures = 0;

    execute_result_buffer_if #(.P_N(32)) bus ();

    execute_result_buffer #(
        .P_N      (32),
        .P_DEPTH  (2),
        .P_DEPTH_N(1)
    ) dut (
        .iCLOCK      (clk),
        .iRESET_SYNC (rst),
        .iEVENT_FLUSH(flush),
        .bus         (bus),
        .oFLAGS      (flags)
`ifdef MIST1032SA_EXECUTE_RESULT_FORWARD_EN
        ,
        .oFWD_VALID      (fwd_valid),
        .oFWD_DESTINATION(fwd_dest),
        .oFWD_DATA       (fwd_data)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] d, input logic [4:0] dst, input logic wb,
                         input logic fwb, input logic [4:0] f);
        bus.iPREV_VALID           = 1'b1;
        bus.iPREV_DATA            = d;
        bus.iPREV_DESTINATION     = dst;
        bus.iPREV_WRITEBACK       = wb;
        bus.iPREV_FLAGS_WRITEBACK = fwb;
        bus.iPREV_FLAGS           = f;
    endtask

    initial begin
        rst                       = 1'b1;
        flush                     = 1'b0;
        bus.iNEXT_BUSY            = 1'b0;
        bus.iPREV_VALID           = 1'b0;
        bus.iPREV_DATA            = '0;
        bus.iPREV_DESTINATION     = '0;
        bus.iPREV_WRITEBACK       = 1'b0;
        bus.iPREV_FLAGS_WRITEBACK = 1'b0;
        bus.iPREV_FLAGS           = '0;

        // Reset held two cycles with upstream offering an entry
        offer(32'h0000_0055, 5'd1, 1'b1, 1'b1, 5'b11111);
        for (int i = 0; i < 2; i++) begin
            tick();
            check_eq("rst_next_valid", {31'd0, bus.oNEXT_VALID}, 32'd0);
            check_eq("rst_prev_busy", {31'd0, bus.oPREV_BUSY}, 32'd0);
            check_eq("rst_flags", {27'd0, flags}, 32'd0);
            check_eq("rst_next_data", bus.oNEXT_DATA, 32'd0);
        end
        rst = 1'b0;
        bus.iNEXT_BUSY = 1'b1;
        offer(32'h0000_0011, 5'd2, 1'b1, 1'b0, 5'b00000);
        tick();
        bus.iPREV_VALID = 1'b0;
        check_eq("first_push_valid", {31'd0, bus.oNEXT_VALID}, 32'd1);
        check_eq("first_push_data", bus.oNEXT_DATA, 32'h0000_0011);
        check_eq("first_push_dest", {27'd0, bus.oNEXT_DESTINATION}, 32'd2);
        check_eq("first_push_wb", {31'd0, bus.oNEXT_WRITEBACK}, 32'd1);
        bus.iNEXT_BUSY = 1'b0;
        tick();
        check_eq("first_pop_empty", {31'd0, bus.oNEXT_VALID}, 32'd0);

        // Streaming: one word in and one out per cycle
        for (int i = 1; i <= 8; i++) begin
            offer(32'(i), 5'd4, 1'b1, 1'b0, 5'b00000);
            tick();
            check_eq("stream_valid", {31'd0, bus.oNEXT_VALID}, 32'd1);
            check_eq("stream_data", bus.oNEXT_DATA, 32'(i));
            check_eq("stream_busy", {31'd0, bus.oPREV_BUSY}, 32'd0);
        end
        bus.iPREV_VALID = 1'b0;
        tick();
        check_eq("stream_drained", {31'd0, bus.oNEXT_VALID}, 32'd0);

        // Backpressure fills the two-entry buffer and blocks the third
        bus.iNEXT_BUSY = 1'b1;
        offer(32'hAAAA_0000, 5'd5, 1'b1, 1'b0, 5'b00000);
        tick();
        check_eq("bp_busy_after_1", {31'd0, bus.oPREV_BUSY}, 32'd0);
        check_eq("bp_head_1", bus.oNEXT_DATA, 32'hAAAA_0000);
        offer(32'hBBBB_0000, 5'd6, 1'b1, 1'b0, 5'b00000);
        tick();
        check_eq("bp_busy_full", {31'd0, bus.oPREV_BUSY}, 32'd1);
        offer(32'hCCCC_0000, 5'd7, 1'b1, 1'b0, 5'b00000);
        for (int i = 0; i < 2; i++) begin
            tick();
            check_eq("bp_stall_busy", {31'd0, bus.oPREV_BUSY}, 32'd1);
            check_eq("bp_stall_data", bus.oNEXT_DATA, 32'hAAAA_0000);
            check_eq("bp_stall_dest", {27'd0, bus.oNEXT_DESTINATION}, 32'd5);
        end
        bus.iNEXT_BUSY = 1'b0;
        tick();
        check_eq("bp_out_2", bus.oNEXT_DATA, 32'hBBBB_0000);
        check_eq("bp_slot_freed", {31'd0, bus.oPREV_BUSY}, 32'd0);
        tick();
        bus.iPREV_VALID = 1'b0;
        check_eq("bp_out_3", bus.oNEXT_DATA, 32'hCCCC_0000);
        check_eq("bp_out_3_dest", {27'd0, bus.oNEXT_DESTINATION}, 32'd7);
        tick();
        check_eq("bp_drained", {31'd0, bus.oNEXT_VALID}, 32'd0);

        // Flag commit only from popped flag-writing entries
        bus.iNEXT_BUSY = 1'b1;
        offer(32'h0000_000A, 5'd8, 1'b0, 1'b1, 5'b10010);
        tick();
        offer(32'h0000_000B, 5'd9, 1'b0, 1'b0, 5'b00001);
        tick();
        bus.iPREV_VALID = 1'b0;
        check_eq("flags_before_pop", {27'd0, flags}, 32'd0);
        bus.iNEXT_BUSY = 1'b0;
        tick();
        check_eq("flags_after_a", {27'd0, flags}, 32'b10010);
        check_eq("head_b", bus.oNEXT_DATA, 32'h0000_000B);
        tick();
        check_eq("flags_after_b", {27'd0, flags}, 32'b10010);
        check_eq("flags_drained", {31'd0, bus.oNEXT_VALID}, 32'd0);

        // Flush with a full buffer and a coincident push
        bus.iNEXT_BUSY = 1'b1;
        offer(32'h0000_0C01, 5'd10, 1'b1, 1'b1, 5'b01100);
        tick();
        offer(32'h0000_0C02, 5'd11, 1'b1, 1'b1, 5'b01100);
        tick();
        check_eq("flush_pre_full", {31'd0, bus.oPREV_BUSY}, 32'd1);
        flush = 1'b1;
        offer(32'hDEAD_BEEF, 5'd12, 1'b1, 1'b1, 5'b11111);
        tick();
        flush = 1'b0;
        bus.iPREV_VALID = 1'b0;
        check_eq("flush_valid", {31'd0, bus.oNEXT_VALID}, 32'd0);
        check_eq("flush_busy", {31'd0, bus.oPREV_BUSY}, 32'd0);
        check_eq("flush_flags", {27'd0, flags}, 32'b10010);
        bus.iNEXT_BUSY = 1'b0;
        tick();
        check_eq("flush_no_emit", {31'd0, bus.oNEXT_VALID}, 32'd0);

        // Flush coinciding with a pop: head flags still commit, push dropped
        bus.iNEXT_BUSY = 1'b1;
        offer(32'h0000_000E, 5'd13, 1'b1, 1'b1, 5'b00111);
        tick();
        bus.iNEXT_BUSY = 1'b0;
        flush = 1'b1;
        offer(32'hDEAD_BEEF, 5'd14, 1'b1, 1'b0, 5'b00000);
        tick();
        flush = 1'b0;
        bus.iPREV_VALID = 1'b0;
        check_eq("flush_pop_flags", {27'd0, flags}, 32'b00111);
        check_eq("flush_pop_valid", {31'd0, bus.oNEXT_VALID}, 32'd0);
        tick();
        check_eq("flush_pop_no_emit", {31'd0, bus.oNEXT_VALID}, 32'd0);

`ifdef MIST1032SA_EXECUTE_RESULT_FORWARD_EN
        // Forwarding picks the newest GPR-writing entry
        bus.iNEXT_BUSY = 1'b1;
        check_eq("fwd_empty", {31'd0, fwd_valid}, 32'd0);
        offer(32'h0000_0010, 5'd3, 1'b1, 1'b0, 5'b00000);
        tick();
        check_eq("fwd_one_data", fwd_data, 32'h0000_0010);
        offer(32'h0000_0020, 5'd3, 1'b1, 1'b0, 5'b00000);
        tick();
        bus.iPREV_VALID = 1'b0;
        check_eq("fwd_valid", {31'd0, fwd_valid}, 32'd1);
        check_eq("fwd_dest", {27'd0, fwd_dest}, 32'd3);
        check_eq("fwd_data", fwd_data, 32'h0000_0020);
        bus.iNEXT_BUSY = 1'b0;
        tick();
        tick();
        check_eq("fwd_drained", {31'd0, fwd_valid}, 32'd0);
`endif

        // Reset clears committed flags
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("rst_clears_flags", {27'd0, flags}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
